spi_bridge: RTL and testbench
=============================

# spi_bridge

SPI slave front end that turns host SPI transactions into a byte stream on a `bidir_bus` for the command parser downstream, and shifts bytes supplied by that parser back out on MISO. It oversamples the SPI pins in the system clock domain and buffers received bytes in a small FIFO so the parser can stall, for example while SDRAM is busy. It sits between the MCU SPI pins and the parser's `bidir_bus.consumer` port.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: RX FIFO entries. Must be a power of two, ≥ 4.
- `SYNC_STAGES`, 2: synchronizer flops on `spi_sck`, `spi_cs_n` and `spi_mosi`. Must be ≥ 2.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `spi_sck` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0). Frequency ≤ clk/4.
- `spi_cs_n` in 1: chip select, active-low.
- `spi_mosi` in 1: host-to-device data, MSB first.
- `spi_miso` out 1: device-to-host data, MSB first.
- `overflow` out 1: sticky flag, RX byte dropped in the current transaction.
- `bus` `bidir_bus.producer`:
  - `rd_data[7:0]`, `rd_valid`, `closed`: outputs.
  - `rd_ready`: input, one-cycle pop pulse.
  - `wr_data[7:0]`, `wr_valid`: inputs.
  - `wr_ready`: output.

## Operation
- Pins pass through `SYNC_STAGES` flops. Edges of SCK and CS are detected on the synchronized values (previous vs current).
- CS falling edge:
  - bit counter := 0;
  - `closed` := 0;
  - `overflow` := 0;
  - TX shift register loaded (see TX below).
- SCK rising edge with CS low:
  - shift synchronized MOSI into the RX shift register LSB;
  - bit counter +1 (3-bit, wraps 7→0).
  - On the 8th rise, the assembled byte is pushed to the FIFO on the next cycle.
- FIFO full at push time: byte dropped, `overflow` := 1. FIFO contents are unchanged.
- `rd_valid` = FIFO not empty, registered. `rd_data` = FIFO head, registered.
- `rd_ready` high for one cycle pops exactly one entry. `rd_valid`/`rd_data` reflect the new head on the following cycle.
- `rd_ready` while `rd_valid` is low is ignored.
- Simultaneous push and pop: both occur, and the count is unchanged.
- CS rising edge:
  - partial byte (counter ≠ 0) discarded;
  - `closed` := 1 and held until the next CS fall.
  - FIFO contents are not flushed; the consumer drains them and sees `closed && !rd_valid`.
- TX:
  - One-byte holding register. `wr_ready` = holding register empty.
  - A `wr_valid && wr_ready` cycle loads it.
  - At CS fall, and on the SCK falling edge that follows the 8th rise, the shift register loads the holding register (which is then emptied). If the holding register is empty, it loads `8'hFF`.
  - MISO = shift register MSB. The shift register shifts left on each SCK falling edge with CS low.
  - While CS is high, `spi_miso` = 1.
- Reset values:
  - `rd_valid` 0, `rd_data` 0, `closed` 1, `overflow` 0;
  - `wr_ready` 1, `spi_miso` 1;
  - FIFO empty, counters 0.
- Reset asserted mid-transfer aborts the transfer. After release, the block waits for a fresh CS fall; SCK edges seen while CS is already low are ignored until then.

## Timing
- Pin → detected edge: `SYNC_STAGES`+1 clk.
- 8th SCK rise on pin → `rd_valid` high: ≤ `SYNC_STAGES`+3 clk, provided the FIFO was empty.
- Pop: `rd_ready` at cycle n → updated `rd_valid`/`rd_data` at n+1.
- The consumer never samples in the cycle it drives `rd_ready`.
- MISO bit valid within `SYNC_STAGES`+2 clk after the SCK fall on pin. This requires SCK low time ≥ `SYNC_STAGES`+3 clk.
- CS rise on pin → `closed` high: `SYNC_STAGES`+1 clk.

## Configuration
- `SPI_BRIDGE_TX_EN` defined: the TX holding register, shift register and MISO path are built as described.
- Undefined:
  - no TX logic;
  - `spi_miso` tied 1;
  - `wr_ready` tied 0;
  - `wr_data`/`wr_valid` ignored;
  - RX behaviour identical.

## Structure
- Shared package `spi_pkg`:
  - `SPI_IDLE_BYTE` = 8'hFF;
  - `spi_byte_t` (logic [7:0]);
  - default `SPI_SYNC_STAGES`.
- Sub-module `sync_fifo`:
  - parameterised depth/width;
  - push/pop/full/empty;
  - registered head output.
- Pin synchronizers and the edge/bit-counter FSM stay in `spi_bridge`.

## Test plan
- **Single-byte receive:** CS fall, shift 0xA5, CS rise → `rd_valid` with `rd_data`=0xA5; after one `rd_ready` pulse, `rd_valid`=0 and `closed`=1.
- **Stalled consumer and overflow:** send 20 bytes 0x00..0x13 with no `rd_ready` (`FIFO_DEPTH`=16) → FIFO holds 0x00..0x0F, `overflow`=1; drain yields 16 bytes in order; next CS fall clears `overflow`.
- **Partial byte on CS rise:** CS fall, 5 SCK bits, CS rise, then a new transaction with 0x3C → only 0x3C delivered.
- **TX path (`SPI_BRIDGE_TX_EN`):**
  - write 0x81 before CS fall;
  - host clocks 2 bytes;
  - MISO returns 0x81 then 0xFF;
  - `wr_ready` returns high after the first load.
- **Simultaneous push and pop:** `rd_ready` pulse coincides with a byte completion at FIFO count 3 → count remains 3, order preserved.
- **Async reset:** `reset_n` low mid-byte → outputs at reset values immediately. SCK edges after release with CS held low produce no data until CS toggles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave bridge.
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    // Byte shifted out on MISO when the parser has nothing queued.
    localparam spi_byte_t SPI_IDLE_BYTE = 8'hFF;

    // Default synchronizer depth on the SPI pins.
    localparam int SPI_SYNC_STAGES = 2;

    // MSB-first receive: the newest bit enters at the LSB.
    function automatic spi_byte_t spi_shift_in(input spi_byte_t cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_bridge_sync_fifo.sv
// Synchronous FIFO with a registered head and a registered empty flag.
// DEPTH must be a power of two (pointers wrap naturally), and at least 4.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      remain;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    // Next pointers, occupancy and the head value that becomes visible next cycle.
    always_comb begin
        do_push  = push_i && (count_q != FULL_COUNT);
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        remain   = count_q - (AW+1)'(do_pop);
        count_d  = remain + (AW+1)'(do_push);
        empty_d  = (count_d == '0);
        // With no older entry left, the head is the byte being written now
        // (memory does not hold it yet); otherwise read it from storage.
        if (remain == '0) begin
            head_d = do_push ? wdata_i : head_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; no reset needed since the head/empty registers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, count and registered output state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = empty_q;
    assign head_o  = head_q;

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: oversampled pins, RX byte FIFO towards the
// command parser, optional TX holding/shift path towards MISO.
// Build option: define SPI_BRIDGE_TX_EN to include the TX path; without it
// MISO idles high, wr_ready is held low and wr_data/wr_valid are ignored.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transaction; waiting for a CS fall (also after reset)
// ST_XFER | CS low after a seen fall; SCK edges shift data
module spi_bridge
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       overflow,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       closed,
    input  logic       rd_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_rise, cs_fall, cs_rise;

    logic [0:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    spi_byte_t  rx_shift_q, rx_shift_d;
    logic       push_q, push_d;
    logic       closed_q, closed_d;
    logic       overflow_q, overflow_d;

    logic       fifo_full, fifo_empty;
    spi_byte_t  fifo_head;

    // Pin synchronizers plus one history flop for edge detection. CS resets
    // low-looking so a CS already low at reset release is not a fresh fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // Transaction FSM, bit counter, RX shifter and status flags.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        push_d     = 1'b0;
        closed_d   = closed_q;
        overflow_d = overflow_q;

        if (push_q && fifo_full) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_XFER;
                    bit_cnt_d  = 3'd0;
                    closed_d   = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_XFER: begin
                if (cs_rise) begin
                    // Any partial byte is dropped by clearing the counter.
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    closed_d  = 1'b1;
                end else if (sck_rise) begin
                    rx_shift_d = spi_shift_in(rx_shift_q, mosi_s);
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    push_d     = (bit_cnt_q == 3'd7);
                end
            end
        endcase
    end

    // FSM and RX state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= '0;
            push_q     <= 1'b0;
            closed_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            push_q     <= push_d;
            closed_q   <= closed_d;
            overflow_q <= overflow_d;
        end
    end

    // The completed byte stays in rx_shift_q for several clocks (SCK is slow),
    // so the push one cycle later can take it straight from the shifter.
    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push_q),
        .wdata_i (rx_shift_q),
        .pop_i   (rd_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_head;
    assign closed   = closed_q;
    assign overflow = overflow_q;

`ifdef SPI_BRIDGE_TX_EN
    logic      sck_fall;
    spi_byte_t hold_q, hold_d;
    spi_byte_t tx_shift_q, tx_shift_d;
    logic      hold_full_q, hold_full_d;
    logic      reload_q, reload_d;
    logic      consume;
    logic      wr_load;

    assign sck_fall = ~sck_s & sck_prev_q;

    // TX holding register and MISO shifter; the shifter reloads at CS fall
    // and on the SCK fall that follows each 8th rise.
    always_comb begin
        tx_shift_d = tx_shift_q;
        reload_d   = reload_q;
        consume    = 1'b0;
        wr_load    = wr_valid && !hold_full_q;

        if (state_q == ST_IDLE) begin
            reload_d = 1'b0;
            if (cs_fall) begin
                consume = 1'b1;
            end
        end else if (cs_rise) begin
            reload_d = 1'b0;
        end else if (sck_rise && (bit_cnt_q == 3'd7)) begin
            reload_d = 1'b1;
        end else if (sck_fall) begin
            if (reload_q) begin
                consume  = 1'b1;
                reload_d = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
        end

        if (consume) begin
            tx_shift_d = hold_full_q ? hold_q : SPI_IDLE_BYTE;
        end
        hold_full_d = (hold_full_q && !consume) || wr_load;
        hold_d      = wr_load ? wr_data : hold_q;
    end

    // TX registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= SPI_IDLE_BYTE;
            reload_q    <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            reload_q    <= reload_d;
        end
    end

    assign wr_ready = ~hold_full_q;
    assign spi_miso = (state_q == ST_XFER) ? tx_shift_q[7] : 1'b1;
`else
    logic unused_tx;
    assign unused_tx = ^{wr_data, wr_valid};
    assign wr_ready  = 1'b0;
    assign spi_miso  = 1'b1;
`endif

endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge with a queue-based reference model.
module tb_spi_bridge;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int HALF  = 6;

`ifdef SPI_BRIDGE_TX_EN
    localparam logic       WR_READY_IDLE = 1'b1;
    localparam logic [7:0] TX_FIRST      = 8'h81;
`else
    localparam logic       WR_READY_IDLE = 1'b0;
    localparam logic [7:0] TX_FIRST      = 8'hFF;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       rd_ready = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       spi_miso, overflow, rd_valid, closed, wr_ready;
    logic [7:0] rd_data;

    spi_bridge #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .overflow (overflow),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .closed   (closed),
        .rd_ready (rd_ready),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    // Reference model: what the consumer should currently see.
    logic [7:0] m_q[$];
    bit m_closed    = 1'b1;
    bit m_ovf       = 1'b0;
    bit m_armed     = 1'b0;
    bit m_cs_high   = 1'b1;
    bit m_hold_full = 1'b0;
    bit chk_en      = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (!m_armed) return;
        if (m_q.size() >= DEPTH) m_ovf = 1'b1;
        else m_q.push_back(b);
    endfunction

    function automatic void model_pop();
        if (m_q.size() > 0) void'(m_q.pop_front());
    endfunction

    // Per-cycle comparison against the model while nothing is in flight.
    always @(posedge clk) begin
        logic exp_wr_ready;
        #1;
        if (chk_en) begin
`ifdef SPI_BRIDGE_TX_EN
            exp_wr_ready = !m_hold_full;
`else
            exp_wr_ready = 1'b0;
`endif
            chk("cmp_rd_valid", rd_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("cmp_rd_data", rd_data, m_q[0]);
            chk("cmp_closed", closed, m_closed);
            chk("cmp_overflow", overflow, m_ovf);
            chk("cmp_wr_ready", wr_ready, exp_wr_ready);
            if (m_cs_high) chk("cmp_miso_idle", spi_miso, 1'b1);
        end
    end

    task automatic cs_low();
        chk_en = 1'b0;
        spi_cs_n = 1'b0;
        tick(6);
        m_cs_high = 1'b0; m_armed = 1'b1; m_closed = 1'b0; m_ovf = 1'b0; m_hold_full = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic cs_high();
        chk_en = 1'b0;
        spi_cs_n = 1'b1;
        tick(6);
        m_cs_high = 1'b1; m_armed = 1'b0; m_closed = 1'b1;
        chk_en = 1'b1;
    endtask

    // Shift nbits of b MSB-first; MISO is sampled just before each SCK rise.
    task automatic send(input logic [7:0] b, input int nbits, input bit pop_mid,
                        output logic [7:0] miso_b, output int lat);
        miso_b = 8'h00;
        lat = -1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = b[i];
            tick(HALF);
            miso_b[i] = spi_miso;
            if (i == 0) chk_en = 1'b0;
            spi_sck = 1'b1;
            if (i == 0 && pop_mid) begin
                tick(3);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
                tick(HALF - 4);
            end else if (i == 0) begin
                for (int k = 1; k <= HALF; k++) begin
                    tick(1);
                    if (lat < 0 && rd_valid) lat = k;
                end
            end else begin
                tick(HALF);
            end
            spi_sck = 1'b0;
            if (i == 0) begin
                if (pop_mid) model_pop();
                model_push(b);
                chk_en = 1'b1;
            end
        end
    endtask

    task automatic pop_one(output logic [7:0] got);
        chk_en = 1'b0;
        got = rd_data;
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        model_pop();
        chk_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] mb, got;
        int lat;

        // Reset values
        tick(3);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_closed", closed, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_miso", spi_miso, 1'b1);
        chk("rst_wr_ready", wr_ready, WR_READY_IDLE);
        reset_n = 1'b1;
        tick(4);
        chk_en = 1'b1;

        // Single-byte receive
        cs_low();
        send(8'hA5, 8, 1'b0, mb, lat);
        chk("t1_latency_ok", (lat >= 1 && lat <= SYNC + 3), 1'b1);
        chk("t1_miso_idle_byte", mb, 8'hFF);
        cs_high();
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_rd_data", rd_data, 8'hA5);
        chk("t1_closed", closed, 1'b1);
        pop_one(got);
        chk("t1_popped", got, 8'hA5);
        tick(1);
        chk("t1_rd_valid_after", rd_valid, 1'b0);
        chk("t1_closed_after", closed, 1'b1);

        // Stalled consumer and overflow
        cs_low();
        for (int i = 0; i < 20; i++) send(8'(i), 8, 1'b0, mb, lat);
        chk("t2_overflow_set", overflow, 1'b1);
        cs_high();
        chk("t2_overflow_sticky", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_valid", rd_valid, 1'b1);
            pop_one(got);
            chk("t2_drain_data", got, 8'(i));
        end
        tick(1);
        chk("t2_empty", rd_valid, 1'b0);
        cs_low();
        chk("t2_overflow_cleared", overflow, 1'b0);
        cs_high();

        // Partial byte discarded on CS rise
        cs_low();
        send(8'hB7, 5, 1'b0, mb, lat);
        cs_high();
        cs_low();
        send(8'h3C, 8, 1'b0, mb, lat);
        cs_high();
        chk("t3_valid", rd_valid, 1'b1);
        pop_one(got);
        chk("t3_data", got, 8'h3C);
        tick(1);
        chk("t3_only_one", rd_valid, 1'b0);

        // TX path (idle bytes when built without it)
        chk_en = 1'b0;
        wr_data = 8'h81;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
`ifdef SPI_BRIDGE_TX_EN
        m_hold_full = 1'b1;
`endif
        chk_en = 1'b1;
        chk("t4_wr_ready_held", wr_ready, 1'b0);
        cs_low();
        chk("t4_wr_ready_after_load", wr_ready, WR_READY_IDLE);
        send(8'h12, 8, 1'b0, mb, lat);
        chk("t4_miso_byte0", mb, TX_FIRST);
        send(8'h34, 8, 1'b0, mb, lat);
        chk("t4_miso_byte1", mb, 8'hFF);
        cs_high();
        pop_one(got);
        chk("t4_rx0", got, 8'h12);
        pop_one(got);
        chk("t4_rx1", got, 8'h34);

        // Simultaneous push and pop at count 3
        cs_low();
        send(8'h11, 8, 1'b0, mb, lat);
        send(8'h22, 8, 1'b0, mb, lat);
        send(8'h33, 8, 1'b0, mb, lat);
        send(8'h44, 8, 1'b1, mb, lat);
        chk("t5_head_after", rd_data, 8'h22);
        cs_high();
        pop_one(got);
        chk("t5_d0", got, 8'h22);
        pop_one(got);
        chk("t5_d1", got, 8'h33);
        pop_one(got);
        chk("t5_d2", got, 8'h44);
        tick(1);
        chk("t5_empty", rd_valid, 1'b0);

        // Async reset mid-byte
        cs_low();
        send(8'h5A, 8, 1'b0, mb, lat);
        send(8'hC3, 4, 1'b0, mb, lat);
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_rd_valid", rd_valid, 1'b0);
        chk("t6_rd_data", rd_data, 8'h00);
        chk("t6_closed", closed, 1'b1);
        chk("t6_overflow", overflow, 1'b0);
        chk("t6_miso", spi_miso, 1'b1);
        chk("t6_wr_ready", wr_ready, WR_READY_IDLE);
        m_q.delete();
        m_closed = 1'b1; m_ovf = 1'b0; m_armed = 1'b0; m_hold_full = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk_en = 1'b1;
        send(8'h96, 8, 1'b0, mb, lat);
        tick(4);
        chk("t6_ignored_valid", rd_valid, 1'b0);
        chk("t6_ignored_closed", closed, 1'b1);
        cs_high();
        cs_low();
        send(8'h77, 8, 1'b0, mb, lat);
        cs_high();
        pop_one(got);
        chk("t6_fresh_data", got, 8'h77);

        tick(4);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
